// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared types and constants for the router crossbar scheduler
package router_pkg;

    localparam int NPORT_C = 8;
    localparam int DA_W    = 4;
    localparam int SELW_C  = $clog2(NPORT_C);

    typedef logic [SELW_C-1:0] port_id_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } osched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick, first requester after ptr wins
module rr_arbiter #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic [IW-1:0] ptr,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] pos;
    logic          found;

    // Scan ptr+1 .. ptr with wrap; N is a power of two so the IW-bit add wraps naturally.
    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        pos    = '0;
        for (int k = 1; k <= N; k++) begin
            pos = ptr + IW'(k);
            if (!found && req[pos]) begin
                found       = 1'b1;
                onehot[pos] = 1'b1;
                idx         = pos;
            end
        end
    end

endmodule

// File: rtl/router_xbar_sched.sv
// rtl/router_xbar_sched.sv - per-output round-robin crossbar scheduler (optional SCHED_TIMEOUT_EN)
module router_xbar_sched
    import router_pkg::*;
#(
    parameter int NPORT = NPORT_C,
    parameter int SELW  = $clog2(NPORT)
`ifdef SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 64
`endif
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [NPORT-1:0]      req_valid,
    input  logic [NPORT*DA_W-1:0] req_da,
    input  logic [NPORT-1:0]      pkt_done,
    output logic [NPORT-1:0]      grant,
    output logic [NPORT-1:0]      out_busy,
    output logic [NPORT*SELW-1:0] out_sel,
    output logic [NPORT-1:0]      bad_da,
    output logic [NPORT-1:0]      timeout
);

    osched_state_e   state_q [NPORT];
    osched_state_e   state_d [NPORT];
    logic [SELW-1:0] sel_q   [NPORT];
    logic [SELW-1:0] sel_d   [NPORT];
    logic [SELW-1:0] ptr_q   [NPORT];
    logic [SELW-1:0] ptr_d   [NPORT];
    logic [NPORT-1:0] cand   [NPORT];
    logic [NPORT-1:0] win_oh [NPORT];
    logic [SELW-1:0]  win_idx[NPORT];
    logic [NPORT-1:0] owns_any;
    logic [NPORT-1:0] grant_d;
    logic [NPORT-1:0] bad_d;
    logic [NPORT-1:0] timeout_d;

`ifdef SCHED_TIMEOUT_EN
    localparam int CNTW = $clog2(TIMEOUT_CYC);
    logic [CNTW-1:0] cnt_q [NPORT];
    logic [CNTW-1:0] cnt_d [NPORT];
`endif

    // Flatten per-output state into the datapath-facing busy and mux select buses.
    always_comb begin
        out_busy = '0;
        out_sel  = '0;
        for (int o = 0; o < NPORT; o++) begin
            out_busy[o]              = (state_q[o] == BUSY);
            out_sel[SELW*o +: SELW] = sel_q[o];
        end
    end

    // Candidate vectors per output; owners and just-granted inputs are masked, bad DAs flagged.
    always_comb begin
        owns_any = '0;
        bad_d    = '0;
        for (int o = 0; o < NPORT; o++) begin
            for (int i = 0; i < NPORT; i++) begin
                if (state_q[o] == BUSY && sel_q[o] == SELW'(i)) begin
                    owns_any[i] = 1'b1;
                end
            end
        end
        for (int o = 0; o < NPORT; o++) begin
            cand[o] = '0;
            for (int i = 0; i < NPORT; i++) begin
                cand[o][i] = req_valid[i] && (req_da[DA_W*i +: DA_W] == DA_W'(o))
                             && !owns_any[i] && !grant[i];
            end
        end
        for (int i = 0; i < NPORT; i++) begin
            bad_d[i] = req_valid[i] && (32'(req_da[DA_W*i +: DA_W]) >= 32'(NPORT));
        end
    end

    for (genvar o = 0; o < NPORT; o++) begin : g_arb
        rr_arbiter #(
            .N  (NPORT),
            .IW (SELW)
        ) u_arb (
            .ptr    (ptr_q[o]),
            .req    (cand[o]),
            .onehot (win_oh[o]),
            .idx    (win_idx[o])
        );
    end

    // Per-output IDLE/BUSY next state: grant on a winner, release on the owner's pkt_done.
    always_comb begin
        grant_d   = '0;
        timeout_d = '0;
        for (int o = 0; o < NPORT; o++) begin
            state_d[o] = state_q[o];
            sel_d[o]   = sel_q[o];
            ptr_d[o]   = ptr_q[o];
`ifdef SCHED_TIMEOUT_EN
            cnt_d[o]   = cnt_q[o];
`endif
            case (state_q[o])
                IDLE: begin
                    if (|cand[o]) begin
                        state_d[o] = BUSY;
                        sel_d[o]   = win_idx[o];
                        grant_d    = grant_d | win_oh[o];
`ifdef SCHED_TIMEOUT_EN
                        cnt_d[o]   = '0;
`endif
                    end
                end
                BUSY: begin
                    if (pkt_done[sel_q[o]]) begin
                        state_d[o] = IDLE;
                        ptr_d[o]   = sel_q[o];
                    end
`ifdef SCHED_TIMEOUT_EN
                    else if (cnt_q[o] == CNTW'(TIMEOUT_CYC - 1)) begin
                        state_d[o]   = IDLE;
                        ptr_d[o]     = sel_q[o];
                        timeout_d[o] = 1'b1;
                    end else begin
                        cnt_d[o] = cnt_q[o] + 1'b1;
                    end
`endif
                end
                default: state_d[o] = IDLE;
            endcase
        end
    end

    // State, owner, pointer and pulse registers; reset gives input 0 first priority.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int o = 0; o < NPORT; o++) begin
                state_q[o] <= IDLE;
                sel_q[o]   <= '0;
                ptr_q[o]   <= SELW'(NPORT - 1);
`ifdef SCHED_TIMEOUT_EN
                cnt_q[o]   <= '0;
`endif
            end
            grant   <= '0;
            bad_da  <= '0;
            timeout <= '0;
        end else begin
            for (int o = 0; o < NPORT; o++) begin
                state_q[o] <= state_d[o];
                sel_q[o]   <= sel_d[o];
                ptr_q[o]   <= ptr_d[o];
`ifdef SCHED_TIMEOUT_EN
                cnt_q[o]   <= cnt_d[o];
`endif
            end
            grant   <= grant_d;
            bad_da  <= bad_d;
            timeout <= timeout_d;
        end
    end

endmodule

// File: tb/tb_router_xbar_sched.sv
// tb/tb_router_xbar_sched.sv - self-checking bench for router_xbar_sched (optional SCHED_TIMEOUT_EN)
module tb_router_xbar_sched;

    logic        clock;
    logic        reset_n;
    logic [7:0]  req_valid;
    logic [31:0] req_da;
    logic [7:0]  pkt_done;
    logic [7:0]  grant;
    logic [7:0]  out_busy;
    logic [23:0] out_sel;
    logic [7:0]  bad_da;
    logic [7:0]  timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [7:0]  rv;
        logic [31:0] da;
        logic [7:0]  pd;
        logic [7:0]  grant;
        logic [7:0]  busy;
        logic [7:0]  bad;
        logic [23:0] sel;
    } vec_t;

    vec_t vec [13];
    vec_t sb_q [$];
    int   order_q [$];

    router_xbar_sched dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_da    (req_da),
        .pkt_done  (pkt_done),
        .grant     (grant),
        .out_busy  (out_busy),
        .out_sel   (out_sel),
        .bad_da    (bad_da),
        .timeout   (timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int w;
        int waited;
        int done_cyc;
        int grant_cyc;
        int seen_to;
        vec_t cur;

        // inputs during the cycle -> outputs after the following edge
        vec[0]  = '{8'h01, 32'h0000_0007, 8'h00, 8'h01, 8'h80, 8'h00, 24'h000000};
        vec[1]  = '{8'h00, 32'h0000_0007, 8'h00, 8'h00, 8'h80, 8'h00, 24'h000000};
        vec[2]  = '{8'h00, 32'h0000_0000, 8'h01, 8'h00, 8'h00, 8'h00, 24'h000000};
        vec[3]  = '{8'h00, 32'h0000_0000, 8'h00, 8'h00, 8'h00, 8'h00, 24'h000000};
        vec[4]  = '{8'h0F, 32'h0000_0123, 8'h00, 8'h0F, 8'h0F, 8'h00, 24'h000053};
        vec[5]  = '{8'h00, 32'h0000_0000, 8'h10, 8'h00, 8'h0F, 8'h00, 24'h000053};
        vec[6]  = '{8'h00, 32'h0000_0000, 8'h0F, 8'h00, 8'h00, 8'h00, 24'h000053};
        vec[7]  = '{8'h20, 32'h00C0_0000, 8'h00, 8'h00, 8'h00, 8'h20, 24'h000053};
        vec[8]  = '{8'h20, 32'h00C0_0000, 8'h00, 8'h00, 8'h00, 8'h20, 24'h000053};
        vec[9]  = '{8'h00, 32'h0000_0000, 8'h00, 8'h00, 8'h00, 8'h00, 24'h000053};
        vec[10] = '{8'h08, 32'h0000_7000, 8'h00, 8'h08, 8'h80, 8'h00, 24'h600053};
        vec[11] = '{8'h08, 32'h0000_7000, 8'h00, 8'h00, 8'h80, 8'h00, 24'h600053};
        vec[12] = '{8'h00, 32'h0000_0000, 8'h00, 8'h00, 8'h80, 8'h00, 24'h600053};

        reset_n   = 1'b0;
        req_valid = '0;
        req_da    = '0;
        pkt_done  = '0;
        tick();
        tick();
        check("rst_grant", grant, 0);
        check("rst_busy", out_busy, 0);
        check("rst_sel", out_sel, 0);
        check("rst_bad", bad_da, 0);
        check("rst_timeout", timeout, 0);
        reset_n = 1'b1;

        for (int k = 0; k < 13; k++) begin
            req_valid = vec[k].rv;
            req_da    = vec[k].da;
            pkt_done  = vec[k].pd;
            sb_q.push_back(vec[k]);
            tick();
            cur = sb_q.pop_front();
            check($sformatf("v%0d_grant", k), grant, cur.grant);
            check($sformatf("v%0d_busy", k), out_busy, cur.busy);
            check($sformatf("v%0d_bad", k), bad_da, cur.bad);
            check($sformatf("v%0d_sel", k), out_sel, cur.sel);
        end

        // asynchronous reset while output 7 is owned by input 3
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_busy", out_busy, 0);
        check("arst_sel", out_sel, 0);
        check("arst_grant", grant, 0);
        tick();
        reset_n = 1'b1;

        // contention on output 7: expect 0,1,2,3,0 with a turnaround after each done
        order_q = '{0, 1, 2, 3, 0, 1};
        req_da    = 32'h0000_7777;
        req_valid = 8'h0F;
        done_cyc  = -100;
        for (int n = 0; n < 5; n++) begin
            waited = 0;
            tick();
            while (grant == 0 && waited < 10) begin
                tick();
                waited++;
            end
            if (grant == 0) begin
                check($sformatf("cont%0d_grant_wait", n), grant, 8'h01 << order_q[0]);
                void'(order_q.pop_front());
            end else begin
                w = order_q.pop_front();
                check($sformatf("cont%0d_order", n), grant, 8'h01 << w);
                check($sformatf("cont%0d_sel7", n), out_sel[23:21], w);
                check($sformatf("cont%0d_busy7", n), out_busy[7], 1);
                if (n > 0) check($sformatf("cont%0d_gap_ok", n), (cyc - done_cyc) >= 2, 1);
                tick();
                req_valid[w] = 1'b0;
                tick();
                tick();
                pkt_done[w]  = 1'b1;
                req_valid[w] = 1'b1;
                done_cyc     = cyc;
                tick();
                pkt_done = '0;
                check($sformatf("cont%0d_release", n), out_busy[7], 0);
            end
        end

        // owner that never signals done: next winner is input 1
        waited = 0;
        tick();
        while (grant == 0 && waited < 10) begin
            tick();
            waited++;
        end
        w = order_q.pop_front();
        check("hang_grant", grant, 8'h01 << w);
        grant_cyc = cyc;
        tick();
        req_valid = '0;
        seen_to   = 0;
`ifdef SCHED_TIMEOUT_EN
        waited = 0;
        while (timeout == 0 && waited < 80) begin
            tick();
            waited++;
        end
        check("to_pulse", timeout, 8'h80);
        check("to_latency", cyc - grant_cyc, 64);
        check("to_busy_drop", out_busy[7], 0);
        tick();
        check("to_one_cycle", timeout, 0);
`else
        for (int k = 0; k < 70; k++) begin
            tick();
            if (timeout != 0) seen_to++;
        end
        check("no_timeout_pulse", seen_to, 0);
        check("hang_busy_held", out_busy, 8'h80);
        check("hang_sel_held", out_sel[23:21], w);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
